// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA 640x480 timing constants, counter types and decoder helpers.
// Both the timing generators and the sync decoder take their defaults from here.
package vga_sync_decoder_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_ACT_START = 144;
  localparam int unsigned VGA_H_ACT_LEN   = 640;
  localparam int unsigned VGA_V_TOTAL     = 521;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_ACT_START = 31;
  localparam int unsigned VGA_V_ACT_LEN   = 480;

  localparam int unsigned VGA_LOCK_LINES  = 4;
  localparam int unsigned VGA_LOCK_FRAMES = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Single-cycle status pulses produced by the decoder.
  typedef struct packed {
    logic line_err;
    logic frame_err;
    logic frame_start;
  } sync_evt_t;

  // True when start <= pos < start+len (all 10-bit unsigned).
  function automatic logic in_window(cnt_t pos, cnt_t start, cnt_t len);
    return (pos >= start) && (pos < cnt_t'(start + len));
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Sync input / recovered timing bundle of the VGA sync decoder.
//   master: drives HS/VS, observes recovered timing (source or bench side)
//   slave : the decoder itself
interface vga_sync_decoder_if;
  import vga_sync_decoder_pkg::*;

  logic HS;
  logic VS;
  cnt_t hcount;
  cnt_t vcount;
  logic active;
  logic hLocked;
  logic vLocked;
  logic locked;
  cnt_t lineLen;
  logic lineErr;
  logic frameErr;
  logic frameStart;

  modport master (
    output HS, VS,
    input  hcount, vcount, active, hLocked, vLocked, locked,
           lineLen, lineErr, frameErr, frameStart
  );

  modport slave (
    input  HS, VS,
    output hcount, vcount, active, hLocked, vLocked, locked,
           lineLen, lineErr, frameErr, frameStart
  );

endinterface

// File: rtl/vga_sync_decoder_edge.sv
// vga_sync_edge: 2-flop synchronizer followed by a 1-flop delay for rise detection.
//   clk25M : pixel clock
//   rstN   : asynchronous active-low reset
//   din    : asynchronous sync input
//   rise_c : high for one cycle when the synchronized input goes 0 -> 1
module vga_sync_edge (
  input  logic clk25M,
  input  logic rstN,
  input  logic din,
  output logic rise_c
);

  logic [1:0] sync_q;
  logic       dly_q;

  // Synchronizer and edge-detect delay.
  always_ff @(posedge clk25M or negedge rstN) begin
    if (!rstN) begin
      sync_q <= 2'b00;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      dly_q  <= sync_q[1];
    end
  end

  assign rise_c = sync_q[1] & ~dly_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers hcount/vcount from HS/VS, measures line and frame
// lengths against nominal timing, declares lock and flags the active region.
//   clk25M : pixel clock
//   rstN   : asynchronous active-low reset
//   bus    : slave side of vga_sync_decoder_if (HS/VS in, recovered timing out)
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned H_ACT_START = VGA_H_ACT_START,
  parameter int unsigned H_ACT_LEN   = VGA_H_ACT_LEN,
  parameter int unsigned V_ACT_START = VGA_V_ACT_START,
  parameter int unsigned V_ACT_LEN   = VGA_V_ACT_LEN,
  parameter int unsigned LOCK_LINES  = VGA_LOCK_LINES,
  parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input logic               clk25M,
  input logic               rstN,
  vga_sync_decoder_if.slave bus
);

  // One extra bit so that a saturated count + 1 never aliases a valid length.
  localparam int unsigned LEN_W = CNT_W + 1;
  localparam int unsigned LL_W  = $clog2(LOCK_LINES + 1);
  localparam int unsigned LF_W  = $clog2(LOCK_FRAMES + 1);

  logic             h_rise_c, v_rise_c;
  logic [LEN_W-1:0] h_len_c, v_len_c;

  cnt_t             hcount_q, hcount_d;
  cnt_t             vcount_q, vcount_d;
  cnt_t             line_len_q, line_len_d;
  logic [LL_W-1:0]  good_lines_q, good_lines_d;
  logic [LF_W-1:0]  good_frames_q, good_frames_d;
  logic             h_seen_q, h_seen_d;
  logic             v_seen_q, v_seen_d;
  logic             v_pend_q, v_pend_d;
  logic             h_to_q, h_to_d;
  logic             h_locked_q, h_locked_d;
  logic             v_locked_q, v_locked_d;
  logic             active_q, active_d;
  sync_evt_t        evt_q, evt_d;

  vga_sync_edge u_hs_edge (
    .clk25M (clk25M),
    .rstN   (rstN),
    .din    (bus.HS),
    .rise_c (h_rise_c)
  );

  vga_sync_edge u_vs_edge (
    .clk25M (clk25M),
    .rstN   (rstN),
    .din    (bus.VS),
    .rise_c (v_rise_c)
  );

  assign h_len_c = {1'b0, hcount_q} + LEN_W'(1);
  assign v_len_c = {1'b0, vcount_q} + LEN_W'(1);

  // Next-state: counters, measurements, lock counters and pulses.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_len_d    = line_len_q;
    good_lines_d  = good_lines_q;
    good_frames_d = good_frames_q;
    h_seen_d      = h_seen_q;
    v_seen_d      = v_seen_q;
    v_pend_d      = v_pend_q;
    h_to_d        = h_to_q;
    evt_d         = '0;

    if (h_rise_c) begin
      hcount_d = '0;
    end else if (!(&hcount_q)) begin
      hcount_d = hcount_q + cnt_t'(1);
    end

    // HS timeout fires once per missing-HS episode; re-armed by the next hRise.
    if (!h_rise_c && (&hcount_q) && !h_to_q) begin
      evt_d.line_err = 1'b1;
      good_lines_d   = '0;
      h_to_d         = 1'b1;
    end

    if (h_rise_c) begin
      h_to_d   = 1'b0;
      h_seen_d = 1'b1;
      // The first hRise after reset only arms line measurement.
      if (h_seen_q) begin
        line_len_d = cnt_t'(h_len_c);
        if (h_len_c == LEN_W'(H_TOTAL)) begin
          if (good_lines_q != LL_W'(LOCK_LINES)) begin
            good_lines_d = good_lines_q + LL_W'(1);
          end
        end else begin
          good_lines_d   = '0;
          evt_d.line_err = 1'b1;
        end
      end

      // A pending (or coincident) vRise is consumed here and restarts the frame.
      if (v_pend_q || v_rise_c) begin
        vcount_d          = '0;
        v_pend_d          = 1'b0;
        v_seen_d          = 1'b1;
        evt_d.frame_start = 1'b1;
        if (v_seen_q) begin
          if (v_len_c == LEN_W'(V_TOTAL)) begin
            if (good_frames_q != LF_W'(LOCK_FRAMES)) begin
              good_frames_d = good_frames_q + LF_W'(1);
            end
          end else begin
            good_frames_d   = '0;
            evt_d.frame_err = 1'b1;
          end
        end
      end else if (!(&vcount_q)) begin
        vcount_d = vcount_q + cnt_t'(1);
      end
    end else if (v_rise_c) begin
      v_pend_d = 1'b1;
    end

    h_locked_d = (good_lines_d == LL_W'(LOCK_LINES));
    v_locked_d = (good_frames_d == LF_W'(LOCK_FRAMES));
    // Evaluated on next-state counters so active lines up with hcount/vcount.
    active_d   = h_locked_d && v_locked_d &&
                 in_window(hcount_d, cnt_t'(H_ACT_START), cnt_t'(H_ACT_LEN)) &&
                 in_window(vcount_d, cnt_t'(V_ACT_START), cnt_t'(V_ACT_LEN));
  end

  // State registers.
  always_ff @(posedge clk25M or negedge rstN) begin
    if (!rstN) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      line_len_q    <= '0;
      good_lines_q  <= '0;
      good_frames_q <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      v_pend_q      <= 1'b0;
      h_to_q        <= 1'b0;
      h_locked_q    <= 1'b0;
      v_locked_q    <= 1'b0;
      active_q      <= 1'b0;
      evt_q         <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_len_q    <= line_len_d;
      good_lines_q  <= good_lines_d;
      good_frames_q <= good_frames_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      v_pend_q      <= v_pend_d;
      h_to_q        <= h_to_d;
      h_locked_q    <= h_locked_d;
      v_locked_q    <= v_locked_d;
      active_q      <= active_d;
      evt_q         <= evt_d;
    end
  end

  assign bus.hcount     = hcount_q;
  assign bus.vcount     = vcount_q;
  assign bus.lineLen    = line_len_q;
  assign bus.hLocked    = h_locked_q;
  assign bus.vLocked    = v_locked_q;
  assign bus.locked     = h_locked_q & v_locked_q;
  assign bus.active     = active_q;
  assign bus.lineErr    = evt_q.line_err;
  assign bus.frameErr   = evt_q.frame_err;
  assign bus.frameStart = evt_q.frame_start;

endmodule
